// File: rtl/tb_mem_pkg.sv
// Shared constants, response type and byte-enable helper for the multi-port testbench memory.
package tb_mem_pkg;

    localparam logic [31:0] TB_MEM_ERR_DATA  = 32'hdeadbeef;
    localparam logic [15:0] TB_MEM_LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic        vld;
        logic [2:0]  port;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] byteen);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{byteen[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/tb_mem_multiport_if.sv
// Request/response bus shared by all requestor ports; port p occupies slice p of each vector.
interface tb_mem_multiport_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    wr;
    logic [NUM_PORTS*32-1:0] addr;
    logic [NUM_PORTS*32-1:0] wdata;
    logic [NUM_PORTS*4-1:0]  byteen;
    logic [NUM_PORTS-1:0]    gnt;
    logic [NUM_PORTS-1:0]    rvalid;
    logic [NUM_PORTS*32-1:0] rdata;
    logic [NUM_PORTS-1:0]    err;

    modport master (output req, wr, addr, wdata, byteen, input gnt, rvalid, rdata, err);
    modport slave  (input req, wr, addr, wdata, byteen, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts after the last granted port.
module rr_arbiter #(
    parameter int NUM = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NUM-1:0] req,
    input  logic           advance,
    output logic [NUM-1:0] gnt
);

    logic [2:0] last_q, last_d;

    // NOTE: combinational blocks give every output a default first so no latch is inferred.
    always_comb begin
        gnt    = '0;
        last_d = last_q;
        for (int i = 1; i <= NUM; i++) begin
            for (int p = 0; p < NUM; p++) begin
                if (gnt == '0 && req[p] && p == (int'(last_q) + i) % NUM) begin
                    gnt[p] = 1'b1;
                    if (advance) last_d = 3'(p);
                end
            end
        end
    end

    // Pointer resets to the last port so the first search begins at port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 3'(NUM - 1);
        else       last_q <= last_d;
    end

endmodule

// File: rtl/tb_mem_multiport.sv
// Multi-port testbench memory: round-robin onto one word array, RD_LATENCY-deep response pipe.
// Optional random grant stall enabled by defining TB_MEM_STALL_EN.
module tb_mem_multiport
    import tb_mem_pkg::*;
#(
    parameter int          NUM_PORTS   = 2,
    parameter int          DEPTH_WORDS = 65536,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          RD_LATENCY  = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic clk,
    input  logic reset,
`ifdef TB_MEM_STALL_EN
    input  logic tb_mem_stall_disable,
`endif
    tb_mem_multiport_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]          mem_q [DEPTH_WORDS];
    logic [NUM_PORTS-1:0] arb_gnt;
    logic                 stall;
    logic                 advance;
    logic                 any_gnt;
    logic [2:0]           sel;
    logic                 sel_wr;
    logic [31:0]          sel_addr, sel_wdata, off;
    logic [3:0]           sel_be;
    logic                 in_win;
    logic [AW-1:0]        widx;
    logic                 mem_we;
    logic [31:0]          mem_wdata, mask;
    logic                 unused_addr_bits;
    rsp_t                 rsp_new, rsp_out;
    rsp_t                 pipe_q [RD_LATENCY];
    rsp_t                 pipe_d [RD_LATENCY];

`ifdef TB_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        stall  = (lfsr_q[2:0] == 3'd0) && !tb_mem_stall_disable;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= TB_MEM_LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign advance = !stall;

    rr_arbiter #(.NUM(NUM_PORTS)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req),
        .advance (advance),
        .gnt     (arb_gnt)
    );

    always_comb begin
        bus.gnt   = stall ? '0 : arb_gnt;
        any_gnt   = |bus.gnt;
        sel       = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.gnt[p]) begin
                sel       = 3'(p);
                sel_wr    = bus.wr[p];
                sel_addr  = bus.addr[p*32 +: 32];
                sel_wdata = bus.wdata[p*32 +: 32];
                sel_be    = bus.byteen[p*4 +: 4];
            end
        end
    end

    // Window test on the upper offset bits is the unsigned (addr - base) < DEPTH_WORDS*4 compare.
    always_comb begin
        off              = sel_addr - ADDR_BASE;
        in_win           = (off[31:AW+2] == '0);
        widx             = off[AW+1:2];
        unused_addr_bits = ^off[1:0];
        mask             = byte_mask(sel_be);
        mem_we           = any_gnt && sel_wr && in_win;
        mem_wdata        = (mem_q[widx] & ~mask) | (sel_wdata & mask);
        rsp_new.vld      = any_gnt;
        rsp_new.port     = sel;
        rsp_new.err      = !in_win;
        if (!in_win)     rsp_new.data = TB_MEM_ERR_DATA;
        else if (sel_wr) rsp_new.data = '0;
        else             rsp_new.data = mem_q[widx];
    end

    // NOTE: the word array has no reset; contents survive reset and only the pipe is flushed.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[widx] <= mem_wdata;
    end

    always_comb begin
        pipe_d[0] = rsp_new;
        for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    always_comb begin
        rsp_out    = pipe_q[RD_LATENCY-1];
        bus.rvalid = '0;
        bus.err    = '0;
        bus.rdata  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rsp_out.vld && rsp_out.port == 3'(p)) begin
                bus.rvalid[p]         = 1'b1;
                bus.err[p]            = rsp_out.err;
                bus.rdata[p*32 +: 32] = rsp_out.data;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_addr_chk
        assert property (@(posedge clk) disable iff (reset)
            bus.req[p] |-> !$isunknown(bus.addr[p*32 +: 32]))
            else $error("unknown addr while req high on port %0d", p);
    end

endmodule

// File: tb/tb_tb_mem_multiport.sv
// Directed bench for tb_mem_multiport: two instances, RD_LATENCY 2 (u_a) and 3 (u_b).
module tb_tb_mem_multiport;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    tb_mem_multiport_if #(.NUM_PORTS(2)) a_if ();
    tb_mem_multiport_if #(.NUM_PORTS(2)) b_if ();

`ifdef TB_MEM_STALL_EN
    logic a_dis;
`endif

    tb_mem_multiport #(.NUM_PORTS(2), .RD_LATENCY(2)) u_a (
        .clk   (clk),
        .reset (reset),
`ifdef TB_MEM_STALL_EN
        .tb_mem_stall_disable (a_dis),
`endif
        .bus   (a_if.slave)
    );

    tb_mem_multiport #(.NUM_PORTS(2), .RD_LATENCY(3)) u_b (
        .clk   (clk),
        .reset (reset),
`ifdef TB_MEM_STALL_EN
        .tb_mem_stall_disable (1'b1),
`endif
        .bus   (b_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit on_b, input int p, input bit rq, input bit w,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be);
        if (on_b) begin
            b_if.req[p] = rq;  b_if.wr[p] = w;
            b_if.addr[p*32 +: 32] = ad;  b_if.wdata[p*32 +: 32] = wd;  b_if.byteen[p*4 +: 4] = be;
        end else begin
            a_if.req[p] = rq;  a_if.wr[p] = w;
            a_if.addr[p*32 +: 32] = ad;  a_if.wdata[p*32 +: 32] = wd;  a_if.byteen[p*4 +: 4] = be;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_if.req = '0; a_if.wr = '0; a_if.addr = '0; a_if.wdata = '0; a_if.byteen = '0;
        b_if.req = '0; b_if.wr = '0; b_if.addr = '0; b_if.wdata = '0; b_if.byteen = '0;
`ifdef TB_MEM_STALL_EN
        a_dis = 1'b1;
`endif
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_gnt",    a_if.gnt, 64'h0);
        check("rst_rvalid", a_if.rvalid, 64'h0);
        check("rst_err",    a_if.err, 64'h0);
        check("rst_rdata",  a_if.rdata, 64'h0);
        check("rst_b_rvalid", b_if.rvalid, 64'h0);
        tick();
        reset = 1'b0;

        // Two continuous requesters alternate starting at port 0
        drive(0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
        drive(0, 1, 1, 0, 32'h4, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t3_gnt%0d", i), a_if.gnt, (i % 2 == 0) ? 64'h1 : 64'h2);
            tick();
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (4) tick();

        // Full write, partial byte-enable write, read back
        drive(0, 0, 1, 1, 32'h100, 32'h1122_3344, 4'hF);
        @(negedge clk); check("t1_gnt_w1", a_if.gnt, 64'h1); tick();
        drive(0, 0, 1, 1, 32'h100, 32'hAABB_CCDD, 4'b0101);
        @(negedge clk); check("t1_gnt_w2", a_if.gnt, 64'h1); tick();
        drive(0, 0, 1, 0, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        check("t1_gnt_rd",     a_if.gnt, 64'h1);
        check("t1_wrsp_vld",   a_if.rvalid, 64'h1);
        check("t1_wrsp_data",  a_if.rdata, 64'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); tick();
        @(negedge clk);
        check("t1_rd_vld",  a_if.rvalid, 64'h1);
        check("t1_rd_data", a_if.rdata[31:0], 64'h11BB_33DD);
        check("t1_rd_err",  a_if.err, 64'h0);
        tick();
        @(negedge clk); check("t1_idle_vld", a_if.rvalid, 64'h0); tick();

        // Out-of-window write and read on port 1 leave word 0 untouched
        drive(0, 0, 1, 1, 32'h0, 32'hCAFE_F00D, 4'hF);
        @(negedge clk); check("t4_gnt_w0", a_if.gnt, 64'h1); tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(0, 1, 1, 1, 32'h0004_0000, 32'h1234_5678, 4'hF);
        @(negedge clk); check("t4_gnt_oow_w", a_if.gnt, 64'h2); tick();
        drive(0, 1, 1, 0, 32'h0004_0000, 32'h0, 4'h0);
        @(negedge clk);
        check("t4_gnt_oow_r", a_if.gnt, 64'h2);
        check("t4_w0_rsp",    a_if.rvalid, 64'h1);
        tick();
        drive(0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("t4_gnt_r0",     a_if.gnt, 64'h1);
        check("t4_oow_w_vld",  a_if.rvalid, 64'h2);
        check("t4_oow_w_err",  a_if.err, 64'h2);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("t4_oow_r_vld",  a_if.rvalid, 64'h2);
        check("t4_oow_r_err",  a_if.err, 64'h2);
        check("t4_oow_r_data", a_if.rdata[63:32], 64'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("t4_r0_vld",  a_if.rvalid, 64'h1);
        check("t4_r0_err",  a_if.err, 64'h0);
        check("t4_r0_data", a_if.rdata[31:0], 64'hCAFE_F00D);
        tick();

        // RD_LATENCY=3: back-to-back reads on port 1 return in order
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 32'h40 + 32'(4 * i), 32'h4040_4040 + 32'(i) * 32'h0404_0404, 4'hF);
            tick();
        end
        drive(1, 1, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (4) tick();
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1, 1, 1, 0, 32'h40 + 32'(4 * i), 32'h0, 4'h0);
            else       drive(1, 1, 0, 0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            if (i < 3) begin
                check($sformatf("t2_gnt%0d", i),    b_if.gnt, 64'h2);
                check($sformatf("t2_early%0d", i),  b_if.rvalid, 64'h0);
            end else if (i < 6) begin
                check($sformatf("t2_vld%0d", i - 3),  b_if.rvalid, 64'h2);
                check($sformatf("t2_data%0d", i - 3), b_if.rdata[63:32],
                      64'(32'h4040_4040 + 32'(i - 3) * 32'h0404_0404));
            end else begin
                check("t2_tail_vld", b_if.rvalid, 64'h0);
            end
            tick();
        end

        // Reset one cycle after a grant drops the in-flight read, memory survives
        drive(0, 0, 1, 0, 32'h100, 32'h0, 4'h0);
        @(negedge clk); check("t5_gnt", a_if.gnt, 64'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); check("t5_in_rst_vld", a_if.rvalid, 64'h0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t5_flush%0d", i), a_if.rvalid, 64'h0);
            tick();
        end
        drive(0, 0, 1, 0, 32'h100, 32'h0, 4'h0);
        @(negedge clk); check("t5_gnt2", a_if.gnt, 64'h1); tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); tick();
        @(negedge clk);
        check("t5_keep_vld",  a_if.rvalid, 64'h1);
        check("t5_keep_data", a_if.rdata[31:0], 64'h11BB_33DD);
        tick();

`ifdef TB_MEM_STALL_EN
        begin : t6
            logic [15:0] l;
            int          exp_st;
            int          obs_st;
            reset = 1'b1;
            a_dis = 1'b0;
            tick();
            reset = 1'b0;
            l = 16'hACE1;
            exp_st = 0;
            obs_st = 0;
            drive(0, 0, 1, 0, 32'h0, 32'h0, 4'h0);
            drive(0, 1, 1, 0, 32'h4, 32'h0, 4'h0);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (l[2:0] == 3'd0) exp_st++;
                if (a_if.gnt == 2'b00) obs_st++;
                tick();
                l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
            end
            check("t6_stalls", 64'(obs_st), 64'(exp_st));
            a_dis = 1'b1;
            obs_st = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (a_if.gnt == 2'b00) obs_st++;
                tick();
            end
            check("t6_no_stalls", 64'(obs_st), 64'h0);
            drive(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
            drive(0, 1, 0, 0, 32'h0, 32'h0, 4'h0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
